// File: rtl/arm_alu.sv
// 32-bit ARM-style ALU (ADD/SUB/AND/ORR) with registered result and NZCV flags.
// One shared adder serves ADD and SUB; outputs update one cycle after operands.
module arm_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [1:0]       ALUControl,
  output logic [WIDTH-1:0] ALUResult,
  output logic [3:0]       ALUFlag
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             is_arith;
  logic [WIDTH-1:0] result_d, result_q;
  logic [3:0]       flag_d, flag_q;

  // SUB reuses the adder as SrcA + ~SrcB + 1; bit WIDTH is the carry out.
  always_comb begin
    b_eff    = ALUControl[0] ? ~SrcB : SrcB;
    sum      = {1'b0, SrcA} + {1'b0, b_eff} + {{WIDTH{1'b0}}, ALUControl[0]};
    is_arith = ~ALUControl[1];
  end

  always_comb begin
    result_d = '0;
    unique case (ALUControl)
      2'b00, 2'b01: result_d = sum[WIDTH-1:0];
      2'b10:        result_d = SrcA & SrcB;
      2'b11:        result_d = SrcA | SrcB;
      default:      result_d = '0;
    endcase
  end

  // Overflow: effective operands agree in sign while the sum's sign differs.
  always_comb begin
    flag_d    = 4'b0000;
    flag_d[3] = result_d[WIDTH-1];
    flag_d[2] = (result_d == '0);
    flag_d[1] = is_arith & sum[WIDTH];
    flag_d[0] = is_arith & (SrcA[WIDTH-1] == b_eff[WIDTH-1]) &
                (sum[WIDTH-1] != SrcA[WIDTH-1]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      flag_q   <= 4'b0000;
    end else begin
      result_q <= result_d;
      flag_q   <= flag_d;
    end
  end

  assign ALUResult = result_q;
  assign ALUFlag   = flag_q;

endmodule

// File: tb/tb_arm_alu.sv
// Scoreboard bench for arm_alu: expected {flags,result} queued at drive time,
// popped and compared one clock edge later.
module tb_arm_alu;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] SrcA, SrcB;
  logic [1:0]       ALUControl;
  logic [WIDTH-1:0] ALUResult;
  logic [3:0]       ALUFlag;

  logic [35:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  arm_alu #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .SrcA(SrcA), .SrcB(SrcB),
    .ALUControl(ALUControl), .ALUResult(ALUResult), .ALUFlag(ALUFlag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Independent golden model using wide signed/unsigned arithmetic.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] ctl);
    longint sa, sb, sr;
    logic [32:0] full;
    logic [31:0] r;
    logic c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 1'b0;
    v = 1'b0;
    case (ctl)
      2'b00: begin
        full = {1'b0, a} + {1'b0, b};
        r = full[31:0];
        c = full[32];
        sr = sa + sb;
        v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      2'b01: begin
        r = a - b;
        c = (a >= b);
        sr = sa - sb;
        v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      2'b10: r = a & b;
      default: r = a | b;
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  task automatic compare_out(input string tag);
    logic [35:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_res"}, ALUResult, e[31:0]);
      check({tag, "_flg"}, {28'd0, ALUFlag}, {28'd0, e[35:32]});
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [1:0] ctl);
    @(negedge clk);
    SrcA = a;
    SrcB = b;
    ALUControl = ctl;
    exp_q.push_back(model(a, b, ctl));
  endtask

  task automatic apply(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] ctl);
    drive(a, b, ctl);
    @(posedge clk);
    #1;
    compare_out(tag);
  endtask

  initial begin
    reset = 1'b1;
    SrcA = 32'h1234_5678;
    SrcB = 32'h0000_0001;
    ALUControl = 2'b00;
    #1;
    check("rst_res", ALUResult, 32'd0);
    check("rst_flg", {28'd0, ALUFlag}, 32'd0);
    @(posedge clk);
    #1;
    check("rst_hold_res", ALUResult, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    apply("add_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 2'b00);
    check("add_ovf_k", {28'd0, ALUFlag}, 32'h9);
    apply("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 2'b00);
    check("add_wrap_k", {28'd0, ALUFlag}, 32'h6);
    apply("sub_eq",   32'h0000_0005, 32'h0000_0005, 2'b01);
    check("sub_eq_k", {28'd0, ALUFlag}, 32'h6);
    apply("sub_brw",  32'h0000_0000, 32'h0000_0001, 2'b01);
    check("sub_brw_k", ALUResult, 32'hFFFF_FFFF);
    apply("sub_ovf",  32'h8000_0000, 32'h0000_0001, 2'b01);
    check("sub_ovf_k", {28'd0, ALUFlag}, 32'h3);
    apply("and",      32'hF0F0_F0F0, 32'h0F0F_0F0F, 2'b10);
    check("and_k", {28'd0, ALUFlag}, 32'h4);
    apply("orr",      32'h8000_0000, 32'h0000_0001, 2'b11);
    check("orr_k", ALUResult, 32'h8000_0001);

    // Back-to-back random stream: every cycle a new op.
    drive($urandom, $urandom, 2'($urandom_range(0, 3)));
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = (i % 5 == 0) ? a : $urandom;
      @(posedge clk);
      #1;
      compare_out("pipe");
      drive(a, b, 2'($urandom_range(0, 3)));
    end
    @(posedge clk);
    #1;
    compare_out("pipe_last");

    // Asynchronous reset mid-cycle with a nonzero result on the outputs.
    drive(32'h0000_00FF, 32'h0000_0F00, 2'b11);
    #2;
    reset = 1'b1;
    #1;
    check("arst_res", ALUResult, 32'd0);
    check("arst_flg", {28'd0, ALUFlag}, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    check("arst_hold", ALUResult, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    SrcA = 32'h0000_0003;
    SrcB = 32'h0000_0004;
    ALUControl = 2'b01;
    exp_q.push_back(model(SrcA, SrcB, ALUControl));
    @(posedge clk);
    #1;
    compare_out("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/arm_alu.md
Name: arm_alu

Overview:
- 32-bit ARM-style integer ALU for the single-cycle/pipelined CPU datapath; computes ADD, SUB, AND and ORR on two operands and produces NZCV condition flags.
- Result and flags are registered: both update on the rising clock edge, one cycle after the operands are presented.
- Sits between the register-file/immediate operand muxes (SrcA, SrcB) and the result mux / condition-flag logic.

Parameters:
- WIDTH, 32, operand and result width in bits. Flag semantics are defined on bit WIDTH-1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset; clears all registered outputs.
- SrcA  input  WIDTH  operand A.
- SrcB  input  WIDTH  operand B.
- ALUControl  input  2  operation select: 00 ADD, 01 SUB, 10 AND, 11 ORR.
- ALUResult  output  WIDTH  registered operation result.
- ALUFlag  output  4  registered flags {N,Z,C,V}: bit3 N, bit2 Z, bit1 C, bit0 V.

Behaviour:
- Reset: while reset=1, ALUResult=0 and ALUFlag=4'b0000, asynchronously and independent of clk. Reset takes effect mid-operation, and the in-flight result is discarded. The first edge after reset deassertion captures the current inputs.
- Latency: exactly 1 cycle. Inputs sampled at rising edge k appear on the outputs after edge k. A new operation is accepted every cycle. There is no handshake and no enable.
- Arithmetic: one shared WIDTH+1-bit adder computes sum = SrcA + (ALUControl[0] ? ~SrcB : SrcB) + ALUControl[0].
  - ADD (00): result = SrcA + SrcB, modulo 2^WIDTH; wrap-around is allowed.
  - SUB (01): result = SrcA - SrcB, modulo 2^WIDTH, computed as SrcA + ~SrcB + 1.
- Logic:
  - AND (10): result = SrcA & SrcB, bitwise.
  - ORR (11): result = SrcA | SrcB, bitwise.
- Flags, computed from the same-cycle result and registered alongside it:
  - N = result[WIDTH-1].
  - Z = 1 iff result == 0.
  - C: for ADD/SUB, the carry out of the adder (bit WIDTH). For SUB, C=1 means no borrow, i.e. SrcA >= SrcB unsigned. For AND/ORR, C=0.
  - V: for ADD/SUB, signed overflow, i.e. the effective operands (SrcA and the possibly-inverted SrcB) have the same sign and the result sign differs. For AND/ORR, V=0.
- Boundary cases:
  - SUB with SrcA==SrcB gives result 0, Z=1, C=1.
  - 0 - 1 gives 0xFFFFFFFF, N=1, C=0.
  - 0x7FFFFFFF + 1 gives 0x80000000, N=1, V=1, C=0.
  - 0xFFFFFFFF + 1 gives 0, Z=1, C=1, V=0.
- Fully defined for all 2-bit ALUControl values; no X propagation from valid inputs.

Test Plan:
- Reset: assert reset after a nonzero result -> ALUResult=0x00000000, ALUFlag=0000 immediately, without waiting for a clk edge. Deassert -> next edge loads the live inputs.
- ADD:
  - 0x7FFFFFFF + 0x00000001, ctl 00 -> one cycle later ALUResult=0x80000000, ALUFlag=1001.
  - 0xFFFFFFFF + 0x00000001 -> 0x00000000, flags 0110.
- SUB:
  - 0x00000005 - 0x00000005, ctl 01 -> 0x00000000, flags 0110.
  - 0x00000000 - 0x00000001 -> 0xFFFFFFFF, flags 1000.
  - 0x80000000 - 0x00000001 -> 0x7FFFFFFF, flags 0011.
- Logic:
  - AND 0xF0F0F0F0 & 0x0F0F0F0F, ctl 10 -> 0x00000000, flags 0100.
  - ORR 0x80000000 | 0x00000001, ctl 11 -> 0x80000001, flags 1000.
- Pipelining: apply a different random op/operand pair every cycle for 20+ cycles -> each output equals the golden model of the inputs from the previous edge, with no dropped or duplicated cycles.
